// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch sequencer between PC register, instruction memory and control unit
//
// Ports:
//   clock, clear        : clock and asynchronous active-high reset
//   pc_in               : current PC value; only the low MEM_ADDR_W bits form the word address
//   start               : fetch request, level-sampled in IDLE, LOAD and HOLD
//   mem_addr, mem_read  : word address and read strobe to instruction memory
//   mem_ready           : memory data valid on mem_data_in (sampled only in WAIT)
//   mem_data_in         : memory read data
//   IncPC               : one-cycle PC increment strobe per successful fetch
//   IR_out, ir_valid    : captured instruction and its valid flag
//   ir_ack              : control unit consumed IR_out
//   busy                : sequencer not idle
//   fetch_err           : sticky memory-timeout flag, cleared only by clear

module fetch_unit #(
    parameter int MEM_ADDR_W = 9,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           pc_in,
    input  logic                  start,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_read,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_data_in,
    output logic                  IncPC,
    output logic [31:0]           IR_out,
    output logic                  ir_valid,
    input  logic                  ir_ack,
    output logic                  busy,
    output logic                  fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_HOLD
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       latch_pc;
    logic       capture;
    logic       timeout;

    // Upper PC bits are deliberately dropped: addresses wrap modulo 2^MEM_ADDR_W.
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc_in[31:MEM_ADDR_W];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_pc  = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch_pc  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_ready) begin
                    capture   = 1'b1;
                    state_nxt = S_LOAD;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD, S_HOLD: begin
                // pc_in already holds PC+1 here (PC register updates mid-LOAD),
                // so a back-to-back latch fetches the next sequential word.
                if (ir_ack) begin
                    if (start) begin
                        latch_pc  = 1'b1;
                        state_nxt = S_ADDR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mem_addr  <= '0;
            wait_cnt  <= '0;
            IR_out    <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (latch_pc) begin
                mem_addr <= pc_in[MEM_ADDR_W-1:0];
            end
            if (state == S_ADDR) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (capture) begin
                IR_out <= mem_data_in;
            end
            if (timeout) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // Strobes decode straight from registered state, so clear kills them at once.
    assign mem_read = (state == S_ADDR) || (state == S_WAIT);
    assign IncPC    = (state == S_LOAD);
    assign ir_valid = (state == S_LOAD) || (state == S_HOLD);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] pc_in;
    logic        start;
    logic [8:0]  mem_addr;
    logic        mem_read;
    logic        mem_ready;
    logic [31:0] mem_data_in;
    logic        IncPC;
    logic [31:0] IR_out;
    logic        ir_valid;
    logic        ir_ack;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    int inc_cnt = 0;
    bit mem_model = 1'b0;

    fetch_unit #(.MEM_ADDR_W(9), .MAX_WAIT(15)) dut (
        .clock       (clock),
        .clear       (clear),
        .pc_in       (pc_in),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_ready   (mem_ready),
        .mem_data_in (mem_data_in),
        .IncPC       (IncPC),
        .IR_out      (IR_out),
        .ir_valid    (ir_valid),
        .ir_ack      (ir_ack),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then sample at the falling edge. The PC model increments
    // on the falling edge while IncPC is high; the optional memory model returns
    // 0x1234_0000 + address.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        if (IncPC === 1'b1) begin
            pc_in = pc_in + 32'd1;
            inc_cnt++;
        end
        if (mem_model) mem_data_in = 32'h1234_0000 + 32'(mem_addr);
    endtask

    initial begin
        clear = 1'b1; pc_in = '0; start = 1'b0; mem_ready = 1'b0;
        mem_data_in = '0; ir_ack = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_ir_valid", 32'(ir_valid), 0);
        check("rst_IR_out", IR_out, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        clear = 1'b0;

        // ack while idle is ignored
        ir_ack = 1'b1; tick();
        check("idle_ack_busy", 32'(busy), 0);
        ir_ack = 1'b0;

        // single zero-wait fetch
        pc_in = 32'h5; mem_ready = 1'b1; mem_data_in = 32'hDEADBEEF; start = 1'b1;
        tick();
        check("s_addr", 32'(mem_addr), 32'h5);
        check("s_read0", 32'(mem_read), 1);
        check("s_busy", 32'(busy), 1);
        start = 1'b0;
        tick();
        check("s_wait_read", 32'(mem_read), 1);
        check("s_wait_valid", 32'(ir_valid), 0);
        tick();
        check("s_IR", IR_out, 32'hDEADBEEF);
        check("s_valid", 32'(ir_valid), 1);
        check("s_inc_cnt", 32'(inc_cnt), 1);
        tick();
        check("s_hold_inc", 32'(IncPC), 0);
        check("s_hold_valid", 32'(ir_valid), 1);
        check("s_pc", pc_in, 32'h6);
        ir_ack = 1'b1; tick();
        check("s_idle", 32'(busy), 0);
        check("s_idle_valid", 32'(ir_valid), 0);
        ir_ack = 1'b0;

        // three wait cycles: ir_valid after edge 5
        pc_in = 32'h10; mem_ready = 1'b0; mem_data_in = 32'h11112222; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("w_valid_low", 32'(ir_valid), 0);
        end
        mem_ready = 1'b1; tick();
        check("w_valid", 32'(ir_valid), 1);
        check("w_IR", IR_out, 32'h11112222);
        check("w_inc_cnt", 32'(inc_cnt), 2);
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        check("w_idle", 32'(busy), 0);

        // timeout: 15 WAIT cycles then IDLE with fetch_err
        pc_in = 32'h30; mem_ready = 1'b0; mem_data_in = 32'h99999999; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        check("t_still_wait", 32'(mem_read), 1);
        check("t_err_low", 32'(fetch_err), 0);
        tick();
        check("t_idle", 32'(busy), 0);
        check("t_err", 32'(fetch_err), 1);
        check("t_IR_kept", IR_out, 32'h11112222);
        check("t_inc_cnt", 32'(inc_cnt), 2);
        tick();
        check("t_err_sticky", 32'(fetch_err), 1);
        mem_ready = 1'b1; mem_data_in = 32'hCAFEF00D; start = 1'b1;
        tick(); start = 1'b0; tick(); tick();
        check("t_refetch_IR", IR_out, 32'hCAFEF00D);
        check("t_refetch_err", 32'(fetch_err), 1);
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;

        // back-to-back with address wrap
        pc_in = 32'h1FF; mem_model = 1'b1; mem_ready = 1'b1; start = 1'b1; ir_ack = 1'b1;
        inc_cnt = 0;
        tick();
        check("b_addr0", 32'(mem_addr), 32'h1FF);
        tick(); tick();
        check("b_IR0", IR_out, 32'h123401FF);
        tick();
        check("b_addr1", 32'(mem_addr), 32'h000);
        tick(); tick();
        check("b_IR1", IR_out, 32'h12340000);
        check("b_inc_cnt", 32'(inc_cnt), 2);
        start = 1'b0; tick(); ir_ack = 1'b0; mem_model = 1'b0;
        check("b_idle", 32'(busy), 0);

        // hold: IR stable, start ignored until ack
        pc_in = 32'h20; mem_data_in = 32'h55AA55AA; start = 1'b1; inc_cnt = 0;
        tick(); tick(); tick();
        check("h_IR", IR_out, 32'h55AA55AA);
        for (int i = 0; i < 10; i++) begin
            mem_data_in = $urandom;
            tick();
            check("h_IR_stable", IR_out, 32'h55AA55AA);
            check("h_valid", 32'(ir_valid), 1);
            check("h_read", 32'(mem_read), 0);
        end
        check("h_inc_cnt", 32'(inc_cnt), 1);
        ir_ack = 1'b1; tick();
        check("h_b2b_addr", 32'(mem_addr), 32'h21);
        check("h_b2b_read", 32'(mem_read), 1);
        ir_ack = 1'b0; start = 1'b0;

        // clear mid-WAIT abandons the fetch
        mem_ready = 1'b0; pc_in = 32'h40; start = 1'b1;
        tick(); start = 1'b0; tick();
        check("c_in_wait", 32'(mem_read), 1);
        inc_cnt = 0;
        clear = 1'b1; #1;
        check("c_busy", 32'(busy), 0);
        check("c_read", 32'(mem_read), 0);
        check("c_IR", IR_out, 0);
        check("c_err", 32'(fetch_err), 0);
        check("c_addr", 32'(mem_addr), 0);
        mem_ready = 1'b1;
        tick(); clear = 1'b0; tick(); tick();
        check("c_no_inc", 32'(inc_cnt), 0);
        check("c_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
